// File: rtl/led_pattern_sequencer_if.sv
// Handshake bundle between the tick/button sources and the LED sequencer.
// master drives the strobes and switches; slave owns the LED and mode outputs.
interface led_pattern_sequencer_if #(
  parameter int NB_LEDS = 4
);
  logic               i_tick;
  logic               i_enable;
  logic               i_dir;
  logic               i_btn;
  logic [NB_LEDS-1:0] o_leds;
  logic [1:0]         o_mode;

  modport master (
    output i_tick,
    output i_enable,
    output i_dir,
    output i_btn,
    input  o_leds,
    input  o_mode
  );

  modport slave (
    input  i_tick,
    input  i_enable,
    input  i_dir,
    input  i_btn,
    output o_leds,
    output o_mode
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED mode controller: rotate / flash / ping-pong on each period strobe.
// A synchronized push-button cycles the mode and reloads the pattern.
module led_pattern_sequencer #(
  parameter int NB_LEDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  led_pattern_sequencer_if.slave bus
);

  localparam logic [1:0] MODE_SHIFT = 2'b00;
  localparam logic [1:0] MODE_FLASH = 2'b01;
  localparam logic [1:0] MODE_PONG  = 2'b10;
  localparam logic [1:0] MODE_BAD   = 2'b11;

  localparam logic [NB_LEDS-1:0] LED_HOME = NB_LEDS'(1);
  localparam logic [NB_LEDS-1:0] LED_OFF  = '0;

  logic sync1_q;
  logic sync2_q;
  logic sync2_dly_q;
  logic btn_edge;

  logic [1:0]         mode_q;
  logic [1:0]         mode_d;
  logic [1:0]         mode_next;
  logic [NB_LEDS-1:0] leds_q;
  logic [NB_LEDS-1:0] leds_d;
  logic               up_q;
  logic               up_d;

  logic               mode_bad;
  logic               advance;
  logic               onehot;
  logic [NB_LEDS-1:0] rot_up;
  logic [NB_LEDS-1:0] rot_dn;
  logic [NB_LEDS-1:0] pong_leds;
  logic               pong_up;
  logic [NB_LEDS-1:0] reload_leds;

  // Two-flop synchronizer plus delayed copy for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync2_dly_q <= 1'b0;
    end else begin
      sync1_q     <= bus.i_btn;
      sync2_q     <= sync1_q;
      sync2_dly_q <= sync2_q;
    end
  end

  assign btn_edge = sync2_q & ~sync2_dly_q;
  assign mode_bad = (mode_q == MODE_BAD);
  assign advance  = bus.i_tick & bus.i_enable;

  assign onehot = (leds_q != '0) &&
                  ((leds_q & (leds_q - LED_HOME)) == '0);

  assign rot_up = {leds_q[NB_LEDS-2:0], leds_q[NB_LEDS-1]};
  assign rot_dn = {leds_q[0], leds_q[NB_LEDS-1:1]};

  always_comb begin
    mode_next = MODE_SHIFT;
    unique case (mode_q)
      MODE_SHIFT: mode_next = MODE_FLASH;
      MODE_FLASH: mode_next = MODE_PONG;
      default:    mode_next = MODE_SHIFT;
    endcase
  end

  assign reload_leds = (mode_next == MODE_FLASH) ? LED_OFF : LED_HOME;

  // Ping-pong bounces at the ends without dwelling there
  always_comb begin
    pong_leds = leds_q;
    pong_up   = up_q;
    if (up_q) begin
      if (leds_q[NB_LEDS-1]) begin
        pong_leds = leds_q >> 1;
        pong_up   = 1'b0;
      end else begin
        pong_leds = leds_q << 1;
      end
    end else begin
      if (leds_q[0]) begin
        pong_leds = leds_q << 1;
        pong_up   = 1'b1;
      end else begin
        pong_leds = leds_q >> 1;
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    leds_d = leds_q;
    up_d   = up_q;
    unique case (1'b1)
      mode_bad: begin
        mode_d = MODE_SHIFT;
        leds_d = LED_HOME;
        up_d   = 1'b1;
      end
      (btn_edge & ~mode_bad): begin
        mode_d = mode_next;
        leds_d = reload_leds;
        up_d   = 1'b1;
      end
      (advance & ~btn_edge & ~mode_bad): begin
        unique case (mode_q)
          MODE_SHIFT: begin
            if (!onehot) begin
              leds_d = LED_HOME;
            end else begin
              leds_d = bus.i_dir ? rot_dn : rot_up;
            end
          end
          MODE_FLASH: begin
            leds_d = ~leds_q;
          end
          MODE_PONG: begin
            if (!onehot) begin
              leds_d = LED_HOME;
              up_d   = 1'b1;
            end else begin
              leds_d = pong_leds;
              up_d   = pong_up;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_SHIFT;
      leds_q <= LED_HOME;
      up_q   <= 1'b1;
    end else begin
      mode_q <= mode_d;
      leds_q <= leds_d;
      up_q   <= up_d;
    end
  end

  assign bus.o_leds = leds_q;
  assign bus.o_mode = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed plan with literal
// expectations plus random traffic against a position-based model.
module tb_led_pattern_sequencer;

  localparam int N = 4;

  logic clk;
  logic rst;

  led_pattern_sequencer_if #(.NB_LEDS(N)) bus ();

  led_pattern_sequencer #(.NB_LEDS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Model: mode number, lit position, bounce direction, flash level
  int       m_mode = 0;
  int       m_pos  = 0;
  bit       m_up   = 1'b1;
  bit       m_fl   = 1'b0;
  bit [2:0] h      = '0;
  bit       e;

  function automatic logic [N-1:0] exp_leds();
    logic [N-1:0] v;
    if (m_mode == 1) v = m_fl ? {N{1'b1}} : '0;
    else             v = N'(1) << m_pos;
    return v;
  endfunction

  // A press seen at edge n changes the mode at edge n+2
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      m_pos  = 0;
      m_up   = 1'b1;
      m_fl   = 1'b0;
      h      = '0;
    end else begin
      e = h[1] && !h[2];
      if (e) begin
        m_mode = (m_mode + 1) % 3;
        m_pos  = 0;
        m_up   = 1'b1;
        m_fl   = 1'b0;
      end else if (bus.i_tick && bus.i_enable) begin
        case (m_mode)
          0: m_pos = bus.i_dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
          1: m_fl = !m_fl;
          default: begin
            if (m_up) begin
              if (m_pos == N - 1) begin
                m_up  = 1'b0;
                m_pos = m_pos - 1;
              end else m_pos = m_pos + 1;
            end else begin
              if (m_pos == 0) begin
                m_up  = 1'b1;
                m_pos = 1;
              end else m_pos = m_pos - 1;
            end
          end
        endcase
      end
      h = {h[1:0], bus.i_btn};
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_leds", 8'(bus.o_leds), 8'(exp_leds()));
      chk("model_mode", 8'(bus.o_mode), 8'(m_mode));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic tick_chk(input string nm, input logic [N-1:0] exp);
    bus.i_tick = 1'b1;
    @(negedge clk);
    bus.i_tick = 1'b0;
    chk(nm, 8'(bus.o_leds), 8'(exp));
  endtask

  task automatic press(input int hold);
    bus.i_btn = 1'b1;
    step(hold);
    bus.i_btn = 1'b0;
    step(4);
  endtask

  logic [N-1:0] seq_a [5] = '{4'b0010, 4'b0100, 4'b1000,
                              4'b0001, 4'b0010};
  logic [N-1:0] seq_p [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                              4'b0010, 4'b0001, 4'b0010, 4'b0100};

  initial begin
    rst          = 1'b1;
    bus.i_tick   = 1'b0;
    bus.i_enable = 1'b1;
    bus.i_dir    = 1'b0;
    bus.i_btn    = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("reset_leds", 8'(bus.o_leds), 8'h01);
    chk("reset_mode", 8'(bus.o_mode), 8'h00);

    for (int i = 0; i < 5; i++) tick_chk("shift_up", seq_a[i]);
    bus.i_dir = 1'b1;
    tick_chk("shift_dn0", 4'b0001);
    tick_chk("shift_dn1", 4'b1000);
    bus.i_dir = 1'b0;

    // Press held 10 cycles: mode changes on the third edge only
    bus.i_btn = 1'b1;
    step(1);
    chk("btn_lat_k", 8'(bus.o_mode), 8'h00);
    step(1);
    chk("btn_lat_k1", 8'(bus.o_mode), 8'h00);
    step(1);
    chk("btn_lat_k2", 8'(bus.o_mode), 8'h01);
    chk("flash_load", 8'(bus.o_leds), 8'h00);
    step(7);
    bus.i_btn = 1'b0;
    step(4);
    chk("held_once", 8'(bus.o_mode), 8'h01);
    tick_chk("flash0", 4'b1111);
    tick_chk("flash1", 4'b0000);
    tick_chk("flash2", 4'b1111);

    bus.i_enable = 1'b0;
    for (int i = 0; i < 4; i++) tick_chk("frozen", 4'b1111);
    bus.i_enable = 1'b1;
    step(3);
    chk("no_queue", 8'(bus.o_leds), 8'hff & 8'(4'b1111));
    tick_chk("reenable", 4'b0000);

    press(3);
    chk("pong_mode", 8'(bus.o_mode), 8'h02);
    chk("pong_load", 8'(bus.o_leds), 8'h01);
    for (int i = 0; i < 8; i++) tick_chk("pong", seq_p[i]);

    // Edge pulse lands on the same edge as a tick
    bus.i_btn = 1'b1;
    step(2);
    bus.i_tick = 1'b1;
    step(1);
    bus.i_tick = 1'b0;
    chk("clash_mode", 8'(bus.o_mode), 8'h00);
    chk("clash_leds", 8'(bus.o_leds), 8'h01);
    bus.i_btn = 1'b0;
    step(3);
    chk("clash_hold", 8'(bus.o_leds), 8'h01);

    press(2);
    press(2);
    chk("pong_again", 8'(bus.o_mode), 8'h02);
    tick_chk("pong_r0", 4'b0010);
    tick_chk("pong_r1", 4'b0100);
    tick_chk("pong_r2", 4'b1000);
    #1 rst = 1'b1;
    #1;
    chk("arst_leds", 8'(bus.o_leds), 8'h01);
    chk("arst_mode", 8'(bus.o_mode), 8'h00);
    step(1);
    rst = 1'b0;
    step(1);
    tick_chk("post_rst", 4'b0010);

    // Random traffic, checked every cycle against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.i_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) bus.i_btn = ~bus.i_btn;
      if ($urandom_range(0, 63) == 0) bus.i_enable = ~bus.i_enable;
      if ($urandom_range(0, 15) == 0) bus.i_dir = ~bus.i_dir;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    bus.i_tick = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
